// File: rtl/rsa_xcel_mont_pkg.sv
// rtl/rsa_xcel_mont_pkg.sv - shared types and widths for the Montgomery multiplier
package rsa_xcel_mont_pkg;

  localparam int WORD_W = 32;
  localparam int ACC_W  = 33;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rsa_xcel_mont_AddReds.sv
// rtl/rsa_xcel_mont_AddReds.sv - combinational chain of p_nsteps Montgomery add-reduce steps
module rsa_xcel_mont_AddReds
  import rsa_xcel_mont_pkg::*;
#(
  parameter int p_nsteps = 4
) (
  input  logic [p_nsteps-1:0] i_x_bits,
  input  logic [WORD_W-1:0]   i_y,
  input  logic [WORD_W-1:0]   i_n,
  input  logic [ACC_W-1:0]    i_acc,
  output logic [ACC_W-1:0]    o_acc
);

  logic [ACC_W-1:0] w_acc;
  logic [ACC_W:0]   w_sum;

  // One extra bit on the sum: acc + y + n can reach 2^34 before halving.
  always_comb begin
    w_acc = i_acc;
    w_sum = '0;
    for (int i = 0; i < p_nsteps; i++) begin
      w_sum = {1'b0, w_acc} + (i_x_bits[i] ? {2'b00, i_y} : '0);
      if (w_sum[0]) begin
        w_sum = w_sum + {2'b00, i_n};
      end
      w_acc = w_sum[ACC_W:1];
    end
    o_acc = w_acc;
  end

endmodule

// File: rtl/rsa_xcel_mont_mul_ctrl.sv
// rtl/rsa_xcel_mont_mul_ctrl.sv - sequencer for 32-bit Montgomery multiply x*y*2^-32 mod n
// Optional busy-cycle counter enabled by macro RSA_XCEL_MONT_PERF_CNT_EN.
module rsa_xcel_mont_mul_ctrl
  import rsa_xcel_mont_pkg::*;
#(
  parameter int p_steps = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_val,
  output logic              req_rdy,
  input  logic [WORD_W-1:0] req_x,
  input  logic [WORD_W-1:0] req_y,
  input  logic [WORD_W-1:0] req_n,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic [WORD_W-1:0] resp_result,
  output logic [31:0]       perf_cycles
);

  localparam int c_iters = WORD_W / p_steps;
  localparam int c_cnt_w = 6;
  localparam logic [c_cnt_w-1:0] c_last = c_iters - 1;
  localparam logic [c_cnt_w-1:0] c_one  = 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WORD_W-1:0]   r_x;
  logic [WORD_W-1:0]   r_y;
  logic [WORD_W-1:0]   r_n;
  logic [ACC_W-1:0]    r_acc;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [ACC_W-1:0]    w_chain_acc;

  rsa_xcel_mont_AddReds #(
    .p_nsteps (p_steps)
  ) u_add_reds (
    .i_x_bits (r_x[p_steps-1:0]),
    .i_y      (r_y),
    .i_n      (r_n),
    .i_acc    (r_acc),
    .o_acc    (w_chain_acc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_rdy     = 1'b0;
    resp_val    = 1'b0;
    resp_result = '0;
    case (r_state)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_val) w_state_nxt = CALC;
      end
      CALC: begin
        if (r_cnt == c_last) w_state_nxt = FINAL;
      end
      FINAL: begin
        w_state_nxt = DONE;
      end
      DONE: begin
        resp_val    = 1'b1;
        resp_result = r_acc[WORD_W-1:0];
        if (resp_rdy) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x   <= '0;
      r_y   <= '0;
      r_n   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_val) begin
            r_x   <= req_x;
            r_y   <= req_y;
            r_n   <= req_n;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        CALC: begin
          r_acc <= w_chain_acc;
          r_x   <= r_x >> p_steps;
          r_cnt <= r_cnt + c_one;
        end
        FINAL: begin
          // Chain output is bounded below 2n, so one conditional subtract suffices.
          if (r_acc >= {1'b0, r_n}) r_acc <= r_acc - {1'b0, r_n};
        end
        default: ;
      endcase
    end
  end

`ifdef RSA_XCEL_MONT_PERF_CNT_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf <= '0;
    end else if (((r_state == CALC) || (r_state == FINAL)) && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_rsa_xcel_mont_mul_ctrl.sv
// tb/tb_rsa_xcel_mont_mul_ctrl.sv - scoreboard bench for rsa_xcel_mont_mul_ctrl
module tb_rsa_xcel_mont_mul_ctrl;

  localparam int P = 4;
  localparam int LAT = 32 / P + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [31:0] req_x, req_y, req_n;
  logic        resp_val;
  logic        resp_rdy = 1'b1;
  logic [31:0] resp_result;
  logic [31:0] perf_cycles;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_req = 0;
  bit force_stall = 0;
  bit rand_rdy = 0;
  bit prev_fire = 0;

  typedef struct {
    logic [31:0] res;
    int          hs;
    bit          seen;
  } exp_t;
  exp_t sb[$];

  rsa_xcel_mont_mul_ctrl #(.p_steps(P)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_n       (req_n),
    .resp_val    (resp_val),
    .resp_rdy    (resp_rdy),
    .resp_result (resp_result),
    .perf_cycles (perf_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    if (force_stall) resp_rdy = 1'b0;
    else if (rand_rdy) resp_rdy = ($urandom_range(0, 3) != 0);
    else resp_rdy = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Modular product, then 32 modular halvings to divide by 2^32.
  function automatic logic [31:0] mont_ref(input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] n);
    longint unsigned r, nn;
    nn = {32'd0, n};
    r = ({32'd0, x} * {32'd0, y}) % nn;
    for (int i = 0; i < 32; i++) r = r[0] ? (r + nn) >> 1 : r >> 1;
    return r[31:0];
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      prev_fire = 0;
    end else begin
      if (prev_fire) chk("req_rdy_after_resp", req_rdy, 1);
      prev_fire = 0;
      if (resp_val) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", resp_val, 0);
        end else begin
          if (!sb[0].seen) begin
            chk("latency", cyc + 1 - sb[0].hs, LAT);
            sb[0].seen = 1;
          end
          chk("resp_result", resp_result, sb[0].res);
          if (resp_rdy) begin
            void'(sb.pop_front());
            prev_fire = 1;
          end
        end
      end else begin
        chk("result_zero_idle", resp_result, 0);
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] n);
    exp_t e;
    int t;
    @(negedge clk);
    req_val = 1'b1;
    req_x = x;
    req_y = y;
    req_n = n;
    t = 0;
    while (!req_rdy && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!req_rdy) begin
      chk("req_timeout", req_rdy, 1);
    end else begin
      e.res = mont_ref(x, y, n);
      e.hs = cyc + 1;
      e.seen = 0;
      sb.push_back(e);
      n_req++;
    end
    @(posedge clk);
    #1;
    req_val = 1'b0;
    req_x = $urandom;
    req_y = $urandom;
    req_n = $urandom;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || resp_val || !req_rdy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic check_perf(input string name);
`ifdef RSA_XCEL_MONT_PERF_CNT_EN
    chk(name, perf_cycles, n_req * (32 / P + 1));
`else
    chk(name, perf_cycles, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, y, n;
    int t;
    reset = 1'b1;
    req_val = 1'b0;
    req_x = '0;
    req_y = '0;
    req_n = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_rdy", req_rdy, 1);
    chk("rst_resp_val", resp_val, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_perf", perf_cycles, 0);
    @(negedge clk);
    reset = 1'b0;

    send(32'd3, 32'd4, 32'd5);
    wait_idle();
    send(32'd3, 32'd5, 32'd7);
    send(32'd1, 32'd1, 32'd3);
    wait_idle();
    send(32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    wait_idle();

    force_stall = 1;
    send(32'd2, 32'd2, 32'd3);
    t = 0;
    while (!resp_val && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("stall_resp_seen", resp_val, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_resp_val", resp_val, 1);
      chk("stall_req_rdy", req_rdy, 0);
      req_val = i[0];
      req_x = 32'd5;
      req_y = 32'd6;
      req_n = 32'd7;
    end
    @(negedge clk);
    req_val = 1'b0;
    force_stall = 0;
    wait_idle();

    rand_rdy = 1;
    repeat (40) begin
      if ($urandom_range(0, 1) != 0) n = $urandom | 32'd1;
      else n = 32'($urandom_range(1, 1000)) * 32'd2 + 32'd1;
      x = $urandom % n;
      y = $urandom % n;
      send(x, y, n);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    rand_rdy = 0;
    check_perf("perf_run");

    send(32'd3, 32'd4, 32'd5);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midcalc_req_rdy", req_rdy, 1);
    chk("midcalc_resp_val", resp_val, 0);
    chk("midcalc_resp_result", resp_result, 0);
    chk("midcalc_perf", perf_cycles, 0);
    sb.delete();
    n_req = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    send(32'd3, 32'd4, 32'd5);
    send(32'd1, 32'd1, 32'd3);
    wait_idle();
    check_perf("perf_two");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rsa_xcel_mont_mul_ctrl.md
RSA_XCEL_MONT_MUL_CTRL -- requirements
Module: rsa_xcel_mont_mul_ctrl

Interface
REQ-001 SHALL have parameter p_steps, default 4, giving add-reduce steps per cycle; legal values 1, 2, 4, 8, 16, 32.
REQ-002 SHALL have ports, in order:
- clk  input  1  sole clock.
- reset  input  1  asynchronous, active-high reset.
- req_val  input  1  request valid.
- req_rdy  output  1  request ready.
- req_x  input  32  multiplicand x.
- req_y  input  32  multiplier y.
- req_n  input  32  odd modulus n.
- resp_val  output  1  response valid.
- resp_rdy  input  1  response ready.
- resp_result  output  32  result x*y*2^-32 mod n.
- perf_cycles  output  32  busy-cycle counter (see Configuration).
REQ-003 SHALL use a single clock; reset asynchronous and active-high.

Function
REQ-004 SHALL implement FSM states IDLE, CALC, FINAL, DONE.
REQ-005 SHALL assert req_rdy only in IDLE and resp_val only in DONE.
REQ-006 SHALL, in IDLE when req_val=1, latch x, y and n, clear the 33-bit accumulator and iteration counter, and go to CALC.
REQ-007 In CALC, each cycle SHALL:
- feed the low p_steps bits of the x register, y, n and the accumulator to the add-reduce chain;
- load the chain's 33-bit output into the accumulator;
- shift the x register right by p_steps;
- increment the counter.
REQ-008 SHALL leave CALC for FINAL after exactly 32/p_steps CALC cycles.
REQ-009 In FINAL, SHALL load acc-{1'b0,n} into the accumulator if acc >= {1'b0,n}, else hold it; SHALL go to DONE in one cycle.
REQ-010 In DONE, SHALL drive resp_result = acc[31:0] and hold it stable while resp_rdy=0; on resp_rdy=1, SHALL return to IDLE.
REQ-011 Latency SHALL be 32/p_steps+2 cycles from the req handshake edge to first resp_val (10 for p_steps=4).
REQ-012 SHALL ignore req_val and all req_* inputs outside IDLE.
REQ-013 The accumulator SHALL be 33 bits; no chain output SHALL be truncated before FINAL.
REQ-014 SHALL drive resp_result to 0 in every state other than DONE.

Reset
REQ-015 Reset asserted at any time, including mid-CALC, SHALL abort the operation asynchronously: state=IDLE, accumulator, x/y/n registers and counter=0, req_rdy=1, resp_val=0, resp_result=0, perf_cycles=0.
REQ-016 After reset deasserts, the first clock edge with req_val=1 SHALL be accepted.

Configuration
REQ-017 Macro RSA_XCEL_MONT_PERF_CNT_EN:
- Defined: perf_cycles SHALL increment once per cycle spent in CALC or FINAL, and SHALL saturate at 32'hFFFFFFFF.
- Undefined: perf_cycles SHALL be tied to 0, and no counter register SHALL exist.

Structure
REQ-018 Package rsa_xcel_mont_pkg SHALL hold:
- the state enum typedef;
- constant word width 32;
- accumulator width 33.
REQ-019 SHALL instantiate exactly one sub-module, rsa_xcel_mont_AddReds, with p_nsteps=p_steps, as the combinational add-reduce chain; all sequencing and registers SHALL reside in this block.

Verification
REQ-020 SHALL cover these scenarios:
- p_steps=4; x=3, y=4, n=5, resp_rdy=1 -> resp_result=2, resp_val first high 10 cycles after the handshake.
- x=3, y=5, n=7 -> resp_result=2; then back-to-back x=1, y=1, n=3 -> resp_result=1, and req_rdy returns high the cycle after the first response handshake.
- x=0, y=32'hFFFFFFFF, n=32'hFFFFFFFB -> resp_result=0.
- x=2, y=2, n=3 with resp_rdy=0 for 5 cycles -> resp_val stays 1 and resp_result=1 stable throughout; req_val pulses during that time are not accepted.
- Reset asserted in the 3rd CALC cycle -> same cycle req_rdy=1, resp_val=0, resp_result=0; the next request x=3, y=4, n=5 returns 2.
- With RSA_XCEL_MONT_PERF_CNT_EN defined and p_steps=4, after two requests -> perf_cycles=18; with the macro undefined -> perf_cycles=0.
